// File: rtl/core_pkg.sv
// core_pkg: shared RV32I decode types for the LETC core
package core_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0] reg_index_t;
  typedef enum logic [4:0] {
    OPC_LOAD     = 5'b00000,
    OPC_MISC_MEM = 5'b00011,
    OPC_OP_IMM   = 5'b00100,
    OPC_AUIPC    = 5'b00101,
    OPC_STORE    = 5'b01000,
    OPC_OP       = 5'b01100,
    OPC_LUI      = 5'b01101,
    OPC_BRANCH   = 5'b11000,
    OPC_JALR     = 5'b11001,
    OPC_JAL      = 5'b11011,
    OPC_SYSTEM   = 5'b11100
  } opcode_e;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_UIMM} instr_format_e;
  typedef struct packed {
    word_t         pc;
    opcode_e       opcode;
    instr_format_e format;
    reg_index_t    rd;
    reg_index_t    rs1;
    reg_index_t    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    word_t         imm;
    logic          illegal;
  } decoded_instr_t;
endpackage

// File: rtl/core_instr_decoder.sv
// core_instr_decoder: combinational RV32I field/immediate extraction and legality check
module core_instr_decoder
  import core_pkg::*;
(
  input  word_t          instr,
  input  word_t          pc,
  output decoded_instr_t dec
);
  instr_format_e fmt, f;
  logic known, illegal;
  word_t imm;
  always_comb begin
    fmt = FMT_R;
    known = 1'b1;
    case (instr[6:2])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: fmt = FMT_I;
      OPC_SYSTEM: fmt = instr[14] ? FMT_UIMM : FMT_I;
      OPC_STORE: fmt = FMT_S;
      OPC_BRANCH: fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL: fmt = FMT_J;
      OPC_OP: fmt = FMT_R;
      default: known = 1'b0;
    endcase
  end
  // illegal words flow as R-format so execute sees a zero immediate
  assign illegal = !known || instr[1:0] != 2'b11;
  assign f = illegal ? FMT_R : fmt;
  assign imm = f == FMT_I    ? {{20{instr[31]}}, instr[31:20]} :
               f == FMT_S    ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
               f == FMT_B    ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
               f == FMT_U    ? {instr[31:12], 12'b0} :
               f == FMT_J    ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
               f == FMT_UIMM ? {27'b0, instr[19:15]} : '0;
  assign dec = '{
    pc:      pc,
    opcode:  opcode_e'(instr[6:2]),
    format:  f,
    rd:      instr[11:7],
    rs1:     instr[19:15],
    rs2:     instr[24:20],
    funct3:  instr[14:12],
    funct7:  instr[31:25],
    imm:     imm,
    illegal: illegal
  };
endmodule

// File: rtl/core_decode_stage.sv
// core_decode_stage: RV32I decode with registered, stallable output and skid slot
module core_decode_stage
  import core_pkg::*;
#(
  parameter bit SKID_ENABLE   = 1'b1,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_if_valid,
  output logic          o_if_ready,
  input  word_t         i_if_instr,
  input  word_t         i_if_pc,
  output logic          o_ex_valid,
  input  logic          i_ex_ready,
  output word_t         o_ex_pc,
  output opcode_e       o_ex_opcode,
  output instr_format_e o_ex_format,
  output reg_index_t    o_ex_rd,
  output reg_index_t    o_ex_rs1,
  output reg_index_t    o_ex_rs2,
  output logic [2:0]    o_ex_funct3,
  output logic [6:0]    o_ex_funct7,
  output word_t         o_ex_imm,
  output logic          o_ex_illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e state;
  decoded_instr_t dec, out_q, skid_q;
  logic accept;
  core_instr_decoder u_dec (.instr(i_if_instr), .pc(i_if_pc), .dec(dec));
  // without the skid slot FULL is unreachable and ready must look through to execute
  assign o_if_ready = SKID_ENABLE ? state != FULL : state == EMPTY || i_ex_ready;
  assign accept = i_if_valid && o_if_ready && !i_flush;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      state <= EMPTY;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          out_q <= dec;
          state <= ONE;
        end
        ONE: if (accept && i_ex_ready) out_q <= dec;
          else if (accept) begin
            skid_q <= dec;
            state <= FULL;
          end else if (i_ex_ready) state <= EMPTY;
        FULL: if (i_ex_ready) begin
          out_q <= skid_q;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
  assign o_ex_valid = state != EMPTY;
  assign o_ex_pc = out_q.pc;
  assign o_ex_opcode = out_q.opcode;
  assign o_ex_format = out_q.format;
  assign o_ex_rd = out_q.rd;
  assign o_ex_rs1 = out_q.rs1;
  assign o_ex_rs2 = out_q.rs2;
  assign o_ex_funct3 = out_q.funct3;
  assign o_ex_funct7 = out_q.funct7;
  assign o_ex_imm = out_q.imm;
  assign o_ex_illegal = CHECK_ILLEGAL && out_q.illegal;
endmodule

// File: tb/tb_core_decode_stage.sv
// tb_core_decode_stage: scoreboard bench for skid and non-skid decode stage instances
module tb_core_decode_stage;
  import core_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  op;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, vld = 1'b0, exr = 1'b1;
  logic [31:0] instr = '0, pc = '0;
  int sel = 0, n_cmp = 0, n_fail = 0;
  logic v [2], r [2];
  exp_t act [2];
  exp_t q0 [$], q1 [$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] pco, immo;
    logic [4:0] opo, rdo, rs1o, rs2o;
    logic [2:0] fmto, f3o;
    logic [6:0] f7o;
    logic illo;
    core_decode_stage #(.SKID_ENABLE((g == 0) ? 1'b1 : 1'b0), .CHECK_ILLEGAL(1'b1)) u_dut (
      .clk(clk), .rst(rst), .i_flush(flush), .i_if_valid(vld && sel == g), .o_if_ready(r[g]),
      .i_if_instr(instr), .i_if_pc(pc), .o_ex_valid(v[g]), .i_ex_ready(exr),
      .o_ex_pc(pco), .o_ex_opcode(opo), .o_ex_format(fmto), .o_ex_rd(rdo), .o_ex_rs1(rs1o),
      .o_ex_rs2(rs2o), .o_ex_funct3(f3o), .o_ex_funct7(f7o), .o_ex_imm(immo), .o_ex_illegal(illo)
    );
    assign act[g] = {pco, opo, fmto, rdo, rs1o, rs2o, f3o, f7o, immo, illo};
  end
  function automatic exp_t mk(logic [31:0] p, logic [4:0] op, logic [2:0] fmt, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] imm, logic ill);
    return {p, op, fmt, rd, rs1, rs2, f3, f7, imm, ill};
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask
  task automatic pop_cmp(int k);
    exp_t e;
    int sz;
    sz = k ? q1.size() : q0.size();
    n_cmp++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL unexpected_output dut%0d got pc=%h payload=%h", k, act[k].pc, act[k]);
    end else begin
      e = k ? q1.pop_front() : q0.pop_front();
      if (act[k] !== e) begin
        n_fail++;
        $display("FAIL decode_out dut%0d pc=%h got=%h expected=%h", k, e.pc, act[k], e);
      end
    end
  endtask
  always @(negedge clk) begin
    if (!rst && !flush && exr) begin
      if (v[0]) pop_cmp(0);
      if (v[1]) pop_cmp(1);
    end
  end
  task automatic send(logic [31:0] ins, logic [31:0] p, exp_t e);
    bit ok;
    int k;
    k = sel;
    ok = 1'b0;
    vld = 1'b1;
    instr = ins;
    pc = p;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = r[k];
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout dut%0d pc=%h got=not_accepted expected=accepted", k, p);
    end else begin
      @(posedge clk);
      if (k != 0) q1.push_back(e);
      else q0.push_back(e);
    end
    #1 vld = 1'b0;
  endtask
  task automatic drain(string name);
    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check(name, q0.size() + q1.size(), 0);
    @(posedge clk);
    #1;
  endtask
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic exp_t nop_at(logic [31:0] p);
    return mk(p, 5'b00100, FMT_I, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'b0, v[0]}, 0);
    check("rst_ready", {31'b0, r[0]}, 1);
    check("rst_pc", act[0].pc, 0);
    check("rst_imm", act[0].imm, 0);
    check("rst_ready_noskid", {31'b0, r[1]}, 1);
    @(posedge clk);
    #1;
    send(32'hFFB1_0093, 32'h100, mk(32'h100, 5'b00100, FMT_I, 1, 2, 27, 0, 7'h7F, 32'hFFFF_FFFB, 0));
    send(32'h0051_2223, 32'h104, mk(32'h104, 5'b01000, FMT_S, 4, 2, 5, 2, 0, 32'h4, 0));
    send(32'hFFDF_F0EF, 32'h108, mk(32'h108, 5'b11011, FMT_J, 1, 31, 29, 7, 7'h7F, 32'hFFFF_FFFC, 0));
    send(32'h3002_D073, 32'h10C, mk(32'h10C, 5'b11100, FMT_UIMM, 0, 5, 0, 5, 7'h18, 32'h5, 0));
    send(32'h0000_0000, 32'h110, mk(32'h110, 5'b00000, FMT_R, 0, 0, 0, 0, 0, 0, 1));
    drain("drain_basic");
    exr = 1'b0;
    send(32'h0020_81B3, 32'h200, mk(32'h200, 5'b01100, FMT_R, 3, 1, 2, 0, 0, 0, 0));
    send(32'h1234_52B7, 32'h204, mk(32'h204, 5'b01101, FMT_U, 5, 8, 3, 5, 7'h09, 32'h1234_5000, 0));
    check("full_ready", {31'b0, r[0]}, 0);
    check("full_valid", {31'b0, v[0]}, 1);
    check("full_hold_pc", act[0].pc, 32'h200);
    fork
      send(32'hFE20_8CE3, 32'h208, mk(32'h208, 5'b11000, FMT_B, 25, 1, 2, 0, 7'h7F, 32'hFFFF_FFF8, 0));
      begin
        repeat (2) @(posedge clk);
        #1;
        check("full_ready_held", {31'b0, r[0]}, 0);
        check("full_hold_imm", act[0].imm, 0);
        exr = 1'b1;
      end
    join
    drain("drain_skid");
    exr = 1'b0;
    send(NOP, 32'h300, nop_at(32'h300));
    send(NOP, 32'h304, nop_at(32'h304));
    vld = 1'b1;
    instr = NOP;
    pc = 32'h308;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    vld = 1'b0;
    q0.delete();
    @(negedge clk);
    check("flush_valid", {31'b0, v[0]}, 0);
    check("flush_ready", {31'b0, r[0]}, 1);
    @(posedge clk);
    #1 exr = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(NOP, 32'h30C, nop_at(32'h30C));
    drain("drain_flush");
    exr = 1'b0;
    send(NOP, 32'h400, nop_at(32'h400));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q0.delete();
    @(negedge clk);
    check("midrst_valid", {31'b0, v[0]}, 0);
    check("midrst_ready", {31'b0, r[0]}, 1);
    check("midrst_pc", act[0].pc, 0);
    check("midrst_fields", {12'b0, act[0].rd, act[0].rs1, act[0].op}, 0);
    @(posedge clk);
    #1 exr = 1'b1;
    send(NOP, 32'h404, nop_at(32'h404));
    drain("drain_rst");
    sel = 1;
    exr = 1'b0;
    send(32'h0020_81B3, 32'h500, mk(32'h500, 5'b01100, FMT_R, 3, 1, 2, 0, 0, 0, 0));
    fork
      begin
        send(32'h1234_52B7, 32'h504, mk(32'h504, 5'b01101, FMT_U, 5, 8, 3, 5, 7'h09, 32'h1234_5000, 0));
        send(32'hFE20_8CE3, 32'h508, mk(32'h508, 5'b11000, FMT_B, 25, 1, 2, 0, 7'h7F, 32'hFFFF_FFF8, 0));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check("noskid_ready", {31'b0, r[1]}, 0);
        check("noskid_hold_pc", act[1].pc, 32'h500);
        exr = 1'b1;
      end
    join
    drain("drain_noskid");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
